// File: rtl/id_stage_if.sv
// Operand interface between decode and execute. The master modport is the
// decode side: it consumes fetch/write-back/control inputs and drives the EX bundle.
interface id_stage_if;
  logic [31:0] IF_Instr;
  logic        IF_Valid;
  logic        ID_Stall;
  logic        ID_Flush;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [4:0]  EX_Shamt;
  logic        EX_ALUSrc1;
  logic        EX_ALUSrc2;
  logic [31:0] EX_RsVal;
  logic [31:0] EX_RtVal;
  logic [31:0] EX_Immediate;
  logic [3:0]  EX_ALUFn;
  logic        EX_RegWrite;
  logic [4:0]  EX_WriteReg;
  logic        EX_Valid;
  logic        ID_Illegal;

  modport master (
    input  IF_Instr, IF_Valid, ID_Stall, ID_Flush,
    input  WB_RegWrite, WB_WriteReg, WB_WriteData,
    output EX_Shamt, EX_ALUSrc1, EX_ALUSrc2, EX_RsVal, EX_RtVal,
    output EX_Immediate, EX_ALUFn, EX_RegWrite, EX_WriteReg, EX_Valid, ID_Illegal
  );

  modport slave (
    output IF_Instr, IF_Valid, ID_Stall, ID_Flush,
    output WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  EX_Shamt, EX_ALUSrc1, EX_ALUSrc2, EX_RsVal, EX_RtVal,
    input  EX_Immediate, EX_ALUFn, EX_RegWrite, EX_WriteReg, EX_Valid, ID_Illegal
  );
endinterface

// File: rtl/id_stage.sv
// Decode / register-read stage: decodes the fetched instruction, reads the
// 32x32 register file and registers the execute-stage operand bundle.
module id_stage #(
  parameter bit BYPASS_EN      = 1'b1,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input logic        clk,
  input logic        rst,
  id_stage_if.master bus
);

  localparam logic [3:0] FN_ADD = 4'b0000, FN_SUB = 4'b0001, FN_AND = 4'b0010,
                         FN_OR  = 4'b0011, FN_XOR = 4'b0100, FN_NOR = 4'b0101,
                         FN_SLT = 4'b0110, FN_SLTU = 4'b0111, FN_SLL = 4'b1000,
                         FN_SRL = 4'b1001, FN_SRA = 4'b1010;

  typedef struct packed {
    logic [4:0]  shamt;
    logic        aluSrc1;
    logic        aluSrc2;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [31:0] immediate;
    logic [3:0]  aluFn;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic        valid;
  } bundle_t;

  logic [31:0] regs_q [32];
  bundle_t     bundle_q, bundle_d, decoded;
  logic        illegal_q, illegal_d;
  logic        legal;

  logic [5:0]  opcode, funct;
  logic [4:0]  rsIdx, rtIdx, rdIdx;
  logic [15:0] imm16;
  logic [31:0] rsRead, rtRead;

  assign opcode = bus.IF_Instr[31:26];
  assign rsIdx  = bus.IF_Instr[25:21];
  assign rtIdx  = bus.IF_Instr[20:16];
  assign rdIdx  = bus.IF_Instr[15:11];
  assign funct  = bus.IF_Instr[5:0];
  assign imm16  = bus.IF_Instr[15:0];

  // Write-through read: an in-flight WB write to the same index is forwarded when enabled
  assign rsRead = (rsIdx == 5'd0) ? 32'd0 :
                  (BYPASS_EN && bus.WB_RegWrite && bus.WB_WriteReg == rsIdx) ? bus.WB_WriteData :
                  regs_q[rsIdx];
  assign rtRead = (rtIdx == 5'd0) ? 32'd0 :
                  (BYPASS_EN && bus.WB_RegWrite && bus.WB_WriteReg == rtIdx) ? bus.WB_WriteData :
                  regs_q[rtIdx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (bus.WB_RegWrite && bus.WB_WriteReg != 5'd0) begin
      regs_q[bus.WB_WriteReg] <= bus.WB_WriteData;
    end
  end

  // Defaults describe the illegal-as-ADD fallback; legal encodings override them
  always_comb begin
    legal              = 1'b0;
    decoded            = '0;
    decoded.shamt      = bus.IF_Instr[10:6];
    decoded.rsVal      = rsRead;
    decoded.rtVal      = rtRead;
    decoded.aluFn      = FN_ADD;
    decoded.valid      = 1'b1;
    if (opcode == 6'h00) begin
      legal            = 1'b1;
      decoded.regWrite = 1'b1;
      decoded.writeReg = rdIdx;
      case (funct)
        6'h20, 6'h21: decoded.aluFn = FN_ADD;
        6'h22, 6'h23: decoded.aluFn = FN_SUB;
        6'h24:        decoded.aluFn = FN_AND;
        6'h25:        decoded.aluFn = FN_OR;
        6'h26:        decoded.aluFn = FN_XOR;
        6'h27:        decoded.aluFn = FN_NOR;
        6'h2A:        decoded.aluFn = FN_SLT;
        6'h2B:        decoded.aluFn = FN_SLTU;
        6'h00:        begin decoded.aluFn = FN_SLL; decoded.aluSrc1 = 1'b1; end
        6'h02:        begin decoded.aluFn = FN_SRL; decoded.aluSrc1 = 1'b1; end
        6'h03:        begin decoded.aluFn = FN_SRA; decoded.aluSrc1 = 1'b1; end
        6'h04:        decoded.aluFn = FN_SLL;
        6'h06:        decoded.aluFn = FN_SRL;
        6'h07:        decoded.aluFn = FN_SRA;
        default: begin
          legal            = 1'b0;
          decoded.regWrite = 1'b0;
          decoded.writeReg = 5'd0;
        end
      endcase
    end else if (opcode >= 6'h08 && opcode <= 6'h0F) begin
      legal             = 1'b1;
      decoded.aluSrc2   = 1'b1;
      decoded.regWrite  = 1'b1;
      decoded.writeReg  = rtIdx;
      decoded.immediate = {{16{imm16[15]}}, imm16};
      case (opcode)
        6'h0A:   decoded.aluFn = FN_SLT;
        6'h0B:   decoded.aluFn = FN_SLTU;
        6'h0C:   begin decoded.aluFn = FN_AND; decoded.immediate = {16'h0, imm16}; end
        6'h0D:   begin decoded.aluFn = FN_OR;  decoded.immediate = {16'h0, imm16}; end
        6'h0E:   begin decoded.aluFn = FN_XOR; decoded.immediate = {16'h0, imm16}; end
        6'h0F:   decoded.immediate = {imm16, 16'h0};
        default: decoded.aluFn = FN_ADD;
      endcase
    end
  end

  // Flush beats stall; a bubble is the all-zero bundle
  always_comb begin
    bundle_d  = bundle_q;
    illegal_d = illegal_q;
    if (bus.ID_Flush) begin
      bundle_d = '0;
    end else if (!bus.ID_Stall) begin
      if (!bus.IF_Valid || (!legal && NOP_ON_ILLEGAL)) bundle_d = '0;
      else                                              bundle_d = decoded;
      if (bus.IF_Valid && !legal && NOP_ON_ILLEGAL) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      bundle_q  <= bundle_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.EX_Shamt     = bundle_q.shamt;
  assign bus.EX_ALUSrc1   = bundle_q.aluSrc1;
  assign bus.EX_ALUSrc2   = bundle_q.aluSrc2;
  assign bus.EX_RsVal     = bundle_q.rsVal;
  assign bus.EX_RtVal     = bundle_q.rtVal;
  assign bus.EX_Immediate = bundle_q.immediate;
  assign bus.EX_ALUFn     = bundle_q.aluFn;
  assign bus.EX_RegWrite  = bundle_q.regWrite;
  assign bus.EX_WriteReg  = bundle_q.writeReg;
  assign bus.EX_Valid     = bundle_q.valid;
  assign bus.ID_Illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, register file bypass,
// immediates, shifts, stall/flush and the sticky illegal flag.
module tb_id_stage;
  localparam bit BYPASS = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  id_stage_if bus();

  id_stage #(.BYPASS_EN(BYPASS), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IF_Valid = 1'b0; bus.IF_Instr = 32'd0; bus.ID_Stall = 1'b0; bus.ID_Flush = 1'b0;
    bus.WB_RegWrite = 1'b0; bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    checks++; if (bus.EX_Valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.EX_Valid); else passes++;
    checks++; if (bus.EX_RsVal !== 32'd0) $display("[TB] FAIL reset_rsval got %h want 0", bus.EX_RsVal); else passes++;
    checks++; if (bus.ID_Illegal !== 1'b0) $display("[TB] FAIL reset_illegal got %b want 0", bus.ID_Illegal); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd5; bus.WB_WriteData = 32'h7;
    step();
    bus.WB_RegWrite = 1'b0;
    bus.IF_Valid = 1'b1; bus.IF_Instr = rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h20);
    step();
    checks++; if (bus.EX_RsVal !== 32'h7) $display("[TB] FAIL add_rs got %h want 7", bus.EX_RsVal); else passes++;
    checks++; if (bus.EX_RtVal !== 32'h0) $display("[TB] FAIL add_rt got %h want 0", bus.EX_RtVal); else passes++;
    checks++; if (bus.EX_ALUFn !== 4'b0000) $display("[TB] FAIL add_fn got %b want 0000", bus.EX_ALUFn); else passes++;
    checks++; if (bus.EX_WriteReg !== 5'd3) $display("[TB] FAIL add_wreg got %0d want 3", bus.EX_WriteReg); else passes++;
    checks++; if (bus.EX_Valid !== 1'b1 || bus.EX_RegWrite !== 1'b1) $display("[TB] FAIL add_valid got %b/%b want 1/1", bus.EX_Valid, bus.EX_RegWrite); else passes++;
  endtask

  task automatic test_bypass();
    logic [31:0] expect9;
    expect9 = BYPASS ? 32'hDEADBEEF : 32'h0;
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd9; bus.WB_WriteData = 32'hDEADBEEF;
    bus.IF_Instr = rType(5'd9, 5'd9, 5'd1, 5'd0, 6'h25);
    step();
    checks++; if (bus.EX_RsVal !== expect9) $display("[TB] FAIL bypass_rs got %h want %h", bus.EX_RsVal, expect9); else passes++;
    checks++; if (bus.EX_RtVal !== expect9) $display("[TB] FAIL bypass_rt got %h want %h", bus.EX_RtVal, expect9); else passes++;
    checks++; if (bus.EX_ALUFn !== 4'b0011) $display("[TB] FAIL or_fn got %b want 0011", bus.EX_ALUFn); else passes++;
    bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'h55;
    bus.IF_Valid = 1'b0;
    step();
    bus.WB_RegWrite = 1'b0;
    bus.IF_Valid = 1'b1; bus.IF_Instr = rType(5'd0, 5'd9, 5'd2, 5'd0, 6'h25);
    step();
    checks++; if (bus.EX_RsVal !== 32'h0) $display("[TB] FAIL r0_read got %h want 0", bus.EX_RsVal); else passes++;
    checks++; if (bus.EX_RtVal !== 32'hDEADBEEF) $display("[TB] FAIL r9_read got %h want deadbeef", bus.EX_RtVal); else passes++;
  endtask

  task automatic test_immediate();
    bus.IF_Instr = iType(6'h08, 5'd0, 5'd4, 16'hFFFF);
    step();
    checks++; if (bus.EX_Immediate !== 32'hFFFFFFFF) $display("[TB] FAIL addi_imm got %h want ffffffff", bus.EX_Immediate); else passes++;
    checks++; if (bus.EX_ALUSrc2 !== 1'b1 || bus.EX_WriteReg !== 5'd4) $display("[TB] FAIL addi_src2_wreg got %b/%0d want 1/4", bus.EX_ALUSrc2, bus.EX_WriteReg); else passes++;
    bus.IF_Instr = iType(6'h0C, 5'd5, 5'd4, 16'hFFFF);
    step();
    checks++; if (bus.EX_Immediate !== 32'h0000FFFF) $display("[TB] FAIL andi_imm got %h want 0000ffff", bus.EX_Immediate); else passes++;
    checks++; if (bus.EX_ALUFn !== 4'b0010) $display("[TB] FAIL andi_fn got %b want 0010", bus.EX_ALUFn); else passes++;
    bus.IF_Instr = iType(6'h0F, 5'd0, 5'd6, 16'h1234);
    step();
    checks++; if (bus.EX_Immediate !== 32'h12340000) $display("[TB] FAIL lui_imm got %h want 12340000", bus.EX_Immediate); else passes++;
    checks++; if (bus.EX_RsVal !== 32'h0 || bus.EX_ALUFn !== 4'b0000) $display("[TB] FAIL lui_rs_fn got %h/%b want 0/0000", bus.EX_RsVal, bus.EX_ALUFn); else passes++;
    bus.IF_Instr = iType(6'h0B, 5'd5, 5'd4, 16'h8000);
    step();
    checks++; if (bus.EX_Immediate !== 32'hFFFF8000 || bus.EX_ALUFn !== 4'b0111) $display("[TB] FAIL sltiu got %h/%b want ffff8000/0111", bus.EX_Immediate, bus.EX_ALUFn); else passes++;
  endtask

  task automatic test_shift();
    bus.IF_Instr = rType(5'd0, 5'd5, 5'd7, 5'd31, 6'h03);
    step();
    checks++; if (bus.EX_ALUFn !== 4'b1010) $display("[TB] FAIL sra_fn got %b want 1010", bus.EX_ALUFn); else passes++;
    checks++; if (bus.EX_ALUSrc1 !== 1'b1 || bus.EX_Shamt !== 5'd31) $display("[TB] FAIL sra_src1_shamt got %b/%0d want 1/31", bus.EX_ALUSrc1, bus.EX_Shamt); else passes++;
    checks++; if (bus.EX_ALUSrc2 !== 1'b0 || bus.EX_RtVal !== 32'h7) $display("[TB] FAIL sra_rt got %b/%h want 0/7", bus.EX_ALUSrc2, bus.EX_RtVal); else passes++;
    bus.IF_Instr = rType(5'd5, 5'd5, 5'd8, 5'd0, 6'h07);
    step();
    checks++; if (bus.EX_ALUSrc1 !== 1'b0 || bus.EX_ALUFn !== 4'b1010) $display("[TB] FAIL srav got %b/%b want 0/1010", bus.EX_ALUSrc1, bus.EX_ALUFn); else passes++;
  endtask

  task automatic test_stall_flush();
    bus.IF_Instr = rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h20);
    step();
    bus.ID_Stall = 1'b1;
    bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd5; bus.WB_WriteData = 32'h99;
    for (int i = 0; i < 3; i++) begin
      bus.IF_Instr = iType(6'h0D, 5'd9, 5'(10 + i), 16'(16'h100 * (i + 1)));
      step();
      checks++; if (bus.EX_RsVal !== 32'h7 || bus.EX_WriteReg !== 5'd3 || bus.EX_Valid !== 1'b1 || bus.EX_ALUSrc2 !== 1'b0)
        $display("[TB] FAIL stall_hold[%0d] got rs=%h wreg=%0d v=%b src2=%b want rs=7 wreg=3 v=1 src2=0", i, bus.EX_RsVal, bus.EX_WriteReg, bus.EX_Valid, bus.EX_ALUSrc2);
      else passes++;
    end
    bus.WB_RegWrite = 1'b0;
    bus.ID_Flush = 1'b1;
    step();
    checks++; if (bus.EX_Valid !== 1'b0 || bus.EX_RegWrite !== 1'b0 || bus.EX_WriteReg !== 5'd0)
      $display("[TB] FAIL flush_stall got v=%b rw=%b wreg=%0d want 0/0/0", bus.EX_Valid, bus.EX_RegWrite, bus.EX_WriteReg);
    else passes++;
    bus.ID_Flush = 1'b0; bus.ID_Stall = 1'b0;
    bus.IF_Instr = rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h20);
    step();
    checks++; if (bus.EX_RsVal !== 32'h99) $display("[TB] FAIL write_during_stall got %h want 99", bus.EX_RsVal); else passes++;
    bus.IF_Valid = 1'b0;
    step();
    checks++; if (bus.EX_Valid !== 1'b0 || bus.EX_RsVal !== 32'h0) $display("[TB] FAIL if_invalid_bubble got %b/%h want 0/0", bus.EX_Valid, bus.EX_RsVal); else passes++;
  endtask

  task automatic test_illegal();
    bus.IF_Valid = 1'b1;
    bus.IF_Instr = iType(6'h3F, 5'd5, 5'd3, 16'h1);
    step();
    checks++; if (bus.EX_Valid !== 1'b0 || bus.EX_RegWrite !== 1'b0) $display("[TB] FAIL illegal_bubble got %b/%b want 0/0", bus.EX_Valid, bus.EX_RegWrite); else passes++;
    checks++; if (bus.ID_Illegal !== 1'b1) $display("[TB] FAIL illegal_flag got %b want 1", bus.ID_Illegal); else passes++;
    bus.IF_Instr = rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h20);
    step();
    checks++; if (bus.ID_Illegal !== 1'b1 || bus.EX_Valid !== 1'b1) $display("[TB] FAIL illegal_sticky got %b/%b want 1/1", bus.ID_Illegal, bus.EX_Valid); else passes++;
    bus.IF_Instr = rType(5'd5, 5'd5, 5'd3, 5'd0, 6'h01);
    step();
    checks++; if (bus.EX_Valid !== 1'b0) $display("[TB] FAIL illegal_funct got %b want 0", bus.EX_Valid); else passes++;
    bus.IF_Instr = rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h20);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.EX_Valid !== 1'b0 || bus.EX_RsVal !== 32'h0 || bus.EX_WriteReg !== 5'd0)
      $display("[TB] FAIL async_reset got v=%b rs=%h wreg=%0d want 0/0/0", bus.EX_Valid, bus.EX_RsVal, bus.EX_WriteReg);
    else passes++;
    checks++; if (bus.ID_Illegal !== 1'b0) $display("[TB] FAIL async_reset_illegal got %b want 0", bus.ID_Illegal); else passes++;
    #1;
    rst = 1'b0;
    step();
    checks++; if (bus.EX_RsVal !== 32'h0 || bus.EX_Valid !== 1'b1) $display("[TB] FAIL regfile_cleared got %h/%b want 0/1", bus.EX_RsVal, bus.EX_Valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_immediate();
    test_shift();
    test_stall_flush();
    test_illegal();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/register-read stage: the producer side of the execute-stage operand interface.
- Takes the fetched instruction and decodes it. Reads the 32x32 register file, which also accepts write-back from WB.
- Registers the full EX operand/control bundle in the ID/EX pipeline register, so the execute stage consumes only flopped signals.
- Handles stall (hold) and flush (bubble insertion).

Parameters:
- BYPASS_EN, 1, 1 = same-cycle WB write is visible to the ID read (write-through); 0 = the read returns the old value.
- NOP_ON_ILLEGAL, 1, 1 = an unsupported opcode/funct becomes a bubble and sets ID_Illegal; 0 = decode as ADD with no write.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IF_Instr  in  32  instruction from fetch; sampled when IF_Valid=1.
- IF_Valid  in  1  IF_Instr is meaningful this cycle.
- ID_Stall  in  1  hold the ID/EX register contents.
- ID_Flush  in  1  load a bubble into ID/EX.
- WB_RegWrite  in  1  write-back enable.
- WB_WriteReg  in  5  write-back register index.
- WB_WriteData  in  32  write-back data.
- EX_Shamt  out  5  instr[10:6], registered.
- EX_ALUSrc1  out  1  1 = ALU input 1 is the shamt; 0 = Rs value.
- EX_ALUSrc2  out  1  1 = ALU input 2 is the immediate; 0 = Rt value.
- EX_RsVal  out  32  Rs register value, registered.
- EX_RtVal  out  32  Rt register value, registered.
- EX_Immediate  out  32  extended immediate, registered.
- EX_ALUFn  out  4  ALU function code, registered.
- EX_RegWrite  out  1  the instruction writes a register.
- EX_WriteReg  out  5  destination index (rd for R-type, rt for I-type).
- EX_Valid  out  1  0 = bubble.
- ID_Illegal  out  1  sticky flag: an unsupported instruction was decoded.

Behaviour:
- Reset (async, rst=1): all 32 registers = 0; every EX_* output = 0; ID_Illegal = 0. Outputs are held at 0 while rst stays high.
- Register file:
  - r0 reads 0 always; writes to r0 are ignored.
  - Writes commit on the clk rising edge when WB_RegWrite=1.
  - BYPASS_EN=1: a combinational read of a register being written this cycle returns WB_WriteData.
- ALUFn codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLT 0110, SLTU 0111, SLL 1000, SRL 1001, SRA 1010.
- R-type (op=0), by funct, all with RegWrite=1 and WriteReg=rd:
  - add/addu 20/21 = ADD.
  - sub/subu 22/23 = SUB.
  - and 24 = AND; or 25 = OR; xor 26 = XOR; nor 27 = NOR.
  - slt 2A = SLT; sltu 2B = SLTU.
  - sll 00, srl 02, sra 03: ALUSrc1=1.
  - sllv 04, srlv 06, srav 07: ALUSrc1=0.
  - Shifts: input 2 is always Rt (ALUSrc2=0).
- I-type, all with ALUSrc2=1, RegWrite=1, WriteReg=rt:
  - addi/addiu 08/09 = ADD.
  - slti 0A = SLT; sltiu 0B = SLTU. The immediate is sign-extended before the unsigned compare.
  - andi 0C = AND; ori 0D = OR; xori 0E = XOR. Immediate is zero-extended.
  - lui 0F = ADD with Immediate = {imm16, 16'h0}. The Rs field is 0, so RsVal=0.
- Sign-extended ops: Immediate = {{16{imm[15]}}, imm}.
- Any other op/funct is illegal:
  - NOP_ON_ILLEGAL=1: load a bubble and set ID_Illegal=1. ID_Illegal stays set until rst.
  - NOP_ON_ILLEGAL=0: decode as ADD with RegWrite=0.
- Pipeline register update on each edge, in priority order:
  - Flush: load a bubble (all EX_* = 0, EX_Valid=0).
  - Else Stall: hold all EX_* outputs.
  - Else: load the decoded bundle. If IF_Valid=0, load a bubble instead.
- Flush with stall in the same cycle: the flush wins.
- Register file writes happen regardless of stall or flush.
- Latency: one cycle from IF_Instr to the EX_* outputs.
- A stalled instruction holds its captured RsVal/RtVal. It does not re-read, even if WB writes that register during the stall.
- A bubble always has EX_RegWrite=0 and EX_WriteReg=0.

Test Plan:
- Reset, then write r5=0x00000007 via WB. Issue add r3,r5,r0 -> next cycle EX_RsVal=7, EX_RtVal=0, ALUFn=0000, WriteReg=3, Valid=1.
- In the same cycle, WB writes r9=0xDEADBEEF and ID decodes or r1,r9,r9 -> EX_RsVal=EX_RtVal=0xDEADBEEF when BYPASS_EN=1; 0 when BYPASS_EN=0. Also WB write to r0 -> later reads of r0 return 0.
- Immediate extension:
  - addi imm=0xFFFF -> EX_Immediate=0xFFFFFFFF, ALUSrc2=1.
  - andi imm=0xFFFF -> 0x0000FFFF.
  - lui imm=0x1234 -> 0x12340000.
- sra rd,rt,shamt=31 -> ALUFn=1010, ALUSrc1=1, EX_Shamt=31. srav -> ALUSrc1=0.
- Stall for 3 cycles with a changing IF_Instr -> EX_* unchanged. Flush asserted with stall -> Valid=0, RegWrite=0 next cycle.
- Opcode 0x3F -> bubble, ID_Illegal=1 sticky. Async rst pulsed mid-cycle -> outputs 0 immediately and ID_Illegal cleared.
